// File: rtl/piano_sequencer.sv
// piano_sequencer: multi-slot run-length-encoded key recorder with looping playback
module piano_sequencer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_MS = 10,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_DEPTH = 256,
  parameter int KEY_ID_BITS = 4,
  parameter int OCTAVE_BITS = 2,
  parameter int DUR_BITS = 8,
  localparam int SLOT_BITS = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SLOT_BITS-1:0]   slot_sel,
  input  logic                   record_level,
  input  logic                   play_pulse,
  input  logic                   stop_pulse,
  input  logic                   clear_pulse,
  input  logic                   loop_en,
  input  logic [KEY_ID_BITS-1:0] live_key_id,
  input  logic                   live_key_is_pressed,
  input  logic                   live_octave_up,
  input  logic                   live_octave_down,
  output logic [KEY_ID_BITS-1:0] playback_key_id,
  output logic                   playback_key_is_pressed,
  output logic                   playback_octave_up,
  output logic                   playback_octave_down,
  output logic                   is_recording,
  output logic                   is_playing,
  output logic [NUM_SLOTS-1:0]   slot_valid,
  output logic                   mem_full
);
  localparam int TICK_CYCLES = TICK_MS * (CLK_FREQ_HZ / 1000);
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam int ADDR_BITS = $clog2(SLOT_DEPTH);
  localparam int SW = OCTAVE_BITS + 1 + KEY_ID_BITS;
  localparam int EW = SW + DUR_BITS;
  typedef enum logic [2:0] {IDLE, RECORD, FLUSH, PLAY_FETCH, PLAY_LOAD, PLAY_HOLD} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [(1 << SLOT_BITS) * SLOT_DEPTH];
  logic [EW-1:0] rd_data;
  logic [SLOT_BITS-1:0] slot;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS:0] len [NUM_SLOTS];
  logic [SW-1:0] cur, sample;
  logic [DUR_BITS-1:0] dur, remaining, pb_dur;
  logic [TW-1:0] cnt;
  logic [OCTAVE_BITS-1:0] live_oct, pb_oct;
  logic [KEY_ID_BITS-1:0] pb_key;
  logic pb_pressed, rec_prev, rise, tick, grow, more, wr_en, full_hit, start, play_n;
  assign is_recording = state == RECORD || state == FLUSH;
  assign is_playing = state == PLAY_FETCH || state == PLAY_LOAD || state == PLAY_HOLD;
  always_comb begin
    live_oct = (live_octave_up && !live_octave_down) ? OCTAVE_BITS'(1) :
               (live_octave_down && !live_octave_up) ? OCTAVE_BITS'(2) : '0;
    sample = {live_oct, live_key_is_pressed, live_key_id};
    rise = record_level && !rec_prev;
    tick = cnt == TW'(TICK_CYCLES - 1);
    grow = sample == cur && dur != '1;
    more = ({1'b0, ptr} + 1'b1) < len[slot];
    {pb_oct, pb_pressed, pb_key, pb_dur} = rd_data;
  end
  always_comb begin
    state_n = state;
    wr_en = 1'b0;
    full_hit = 1'b0;
    case (state)
      IDLE: state_n = rise ? RECORD : (play_pulse && slot_valid[slot_sel]) ? PLAY_FETCH : IDLE;
      RECORD: begin
        wr_en = record_level && !stop_pulse && tick && !grow && dur != '0;
        full_hit = wr_en && ptr == '1;
        state_n = (!record_level || stop_pulse) ? FLUSH : full_hit ? IDLE : RECORD;
      end
      FLUSH: begin
        wr_en = dur != '0;
        state_n = IDLE;
      end
      PLAY_FETCH: state_n = stop_pulse ? IDLE : PLAY_LOAD;
      PLAY_LOAD: state_n = stop_pulse ? IDLE : PLAY_HOLD;
      PLAY_HOLD: state_n = stop_pulse ? IDLE : !(tick && remaining <= DUR_BITS'(1)) ? PLAY_HOLD :
                           (more || loop_en) ? PLAY_FETCH : IDLE;
      default: state_n = IDLE;
    endcase
    start = state == IDLE && state_n != IDLE;
    play_n = state_n inside {PLAY_FETCH, PLAY_LOAD, PLAY_HOLD};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rec_prev <= record_level;
      slot <= '0;
      ptr <= '0;
      cur <= '0;
      dur <= '0;
      remaining <= '0;
      slot_valid <= '0;
      mem_full <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) len[i] <= '0;
      playback_key_id <= '0;
      playback_key_is_pressed <= 1'b0;
      playback_octave_up <= 1'b0;
      playback_octave_down <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (tick || start) ? '0 : cnt + 1'b1;
      rec_prev <= record_level;
      case (state)
        IDLE:
          if (state_n == RECORD) begin
            slot <= slot_sel;
            ptr <= '0;
            cur <= sample;
            dur <= '0;
            slot_valid[slot_sel] <= 1'b0;
            len[slot_sel] <= '0;
            mem_full <= 1'b0;
          end else if (state_n == PLAY_FETCH) begin
            slot <= slot_sel;
            ptr <= '0;
          end else if (clear_pulse) begin
            slot_valid[slot_sel] <= 1'b0;
            len[slot_sel] <= '0;
          end
        RECORD:
          if (full_hit) begin
            len[slot] <= (ADDR_BITS + 1)'(SLOT_DEPTH);
            slot_valid[slot] <= 1'b1;
            mem_full <= 1'b1;
          end else if (state_n == RECORD && tick) begin
            // cur always takes the new sample: on a grow it is already equal
            cur <= sample;
            dur <= grow ? dur + 1'b1 : (dur == '0) ? '0 : DUR_BITS'(1);
            if (wr_en) ptr <= ptr + 1'b1;
          end
        FLUSH: begin
          len[slot] <= {1'b0, ptr} + (ADDR_BITS + 1)'(dur != '0);
          slot_valid[slot] <= ptr != '0 || dur != '0;
        end
        PLAY_LOAD: remaining <= pb_dur;
        PLAY_HOLD:
          if (tick) begin
            remaining <= remaining - 1'b1;
            if (state_n == PLAY_FETCH) ptr <= more ? ptr + 1'b1 : '0;
          end
        default: ;
      endcase
      // outputs hold through FETCH/LOAD so consecutive entries join without a gap
      if (!play_n) begin
        playback_key_id <= '0;
        playback_key_is_pressed <= 1'b0;
        playback_octave_up <= 1'b0;
        playback_octave_down <= 1'b0;
      end else if (state == PLAY_LOAD) begin
        playback_key_id <= pb_key;
        playback_key_is_pressed <= pb_pressed;
        playback_octave_up <= pb_oct == OCTAVE_BITS'(1);
        playback_octave_down <= pb_oct == OCTAVE_BITS'(2);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[{slot, ptr}] <= {cur, dur};
    rd_data <= mem[{slot, ptr}];
  end
endmodule

// File: tb/tb_piano_sequencer.sv
// tb_piano_sequencer: table-driven record/playback checks with a per-cycle playback scoreboard
module tb_piano_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slot_sel = 1'b0;
  logic record_level = 1'b0, play_pulse = 1'b0, stop_pulse = 1'b0, clear_pulse = 1'b0, loop_en = 1'b0;
  logic [3:0] live_key_id = '0;
  logic live_key_is_pressed = 1'b0, live_octave_up = 1'b0, live_octave_down = 1'b0;
  logic [3:0] playback_key_id;
  logic playback_key_is_pressed, playback_octave_up, playback_octave_down;
  logic is_recording, is_playing, mem_full;
  logic [1:0] slot_valid;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [3:0] key;
    logic pr;
    logic up;
    logic dn;
    logic [7:0] n;
  } row_t;
  row_t rec_a[$], exp_a[$], rec_b[$], exp_b[$], rec_f[$], exp_f[$], rec_o[$], exp_o[$], rec_r[$];
  row_t sq[$], eq[$];
  logic [7:0] sb[$];
  wire [7:0] obs = {is_playing, playback_key_id, playback_key_is_pressed, playback_octave_up, playback_octave_down};

  piano_sequencer #(
    .CLK_FREQ_HZ(1000), .TICK_MS(4), .NUM_SLOTS(2), .SLOT_DEPTH(8),
    .KEY_ID_BITS(4), .OCTAVE_BITS(2), .DUR_BITS(3)
  ) dut (
    .clk(clk), .rst(rst), .slot_sel(slot_sel), .record_level(record_level),
    .play_pulse(play_pulse), .stop_pulse(stop_pulse), .clear_pulse(clear_pulse), .loop_en(loop_en),
    .live_key_id(live_key_id), .live_key_is_pressed(live_key_is_pressed),
    .live_octave_up(live_octave_up), .live_octave_down(live_octave_down),
    .playback_key_id(playback_key_id), .playback_key_is_pressed(playback_key_is_pressed),
    .playback_octave_up(playback_octave_up), .playback_octave_down(playback_octave_down),
    .is_recording(is_recording), .is_playing(is_playing), .slot_valid(slot_valid), .mem_full(mem_full)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input int key, input bit pr, input bit up, input bit dn, input int n);
    mk = {4'(key), pr, up, dn, 8'(n)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_live(input row_t r);
    live_key_id = r.key;
    live_key_is_pressed = r.pr;
    live_octave_up = r.up;
    live_octave_down = r.dn;
  endtask

  // each segment of sq is held for n ticks; ticks fall every 4th edge after the start edge
  task automatic record_run(input bit s, input bit rel);
    @(negedge clk);
    slot_sel = s;
    record_level = 1'b1;
    drive_live(sq[0]);
    @(posedge clk);
    @(negedge clk);
    chk("rec_active", is_recording, 1);
    for (int i = 0; i < sq.size(); i++) begin
      repeat (4 * int'(sq[i].n)) @(posedge clk);
      @(negedge clk);
      if (i + 1 < sq.size()) drive_live(sq[i + 1]);
    end
    if (rel) begin
      record_level = 1'b0;
      drive_live(mk(0, 0, 0, 0, 0));
      @(negedge clk);
      chk("rec_flush", is_recording, 1);
      @(negedge clk);
      chk("rec_done", is_recording, 0);
    end
  endtask

  // expected playback from eq: two silent cycles, then 4*dur cycles per entry,
  // the final entry 2 shorter because there is no next fetch to hold through
  task automatic play_run(input bit s, input bit lp, input int reps, input int partial);
    int idx;
    sb.delete();
    repeat (2) sb.push_back(8'h80);
    for (int r = 0; r < reps; r++)
      for (int k = 0; k < eq.size(); k++) begin
        int cnt;
        cnt = 4 * int'(eq[k].n);
        if (!lp && k == eq.size() - 1) cnt -= 2;
        repeat (cnt) sb.push_back({1'b1, eq[k].key, eq[k].pr, eq[k].up, eq[k].dn});
      end
    repeat (partial) sb.push_back({1'b1, eq[0].key, eq[0].pr, eq[0].up, eq[0].dn});
    if (!lp) repeat (3) sb.push_back(8'h00);
    @(negedge clk);
    slot_sel = s;
    loop_en = lp;
    play_pulse = 1'b1;
    @(posedge clk);
    idx = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      play_pulse = 1'b0;
      chk($sformatf("play%0d[%0d]", s, idx), obs, sb.pop_front());
      idx++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rec_a.push_back(mk(3, 1, 0, 0, 5));
    rec_a.push_back(mk(0, 0, 0, 0, 2));
    exp_a.push_back(mk(3, 1, 0, 0, 5));
    exp_a.push_back(mk(0, 0, 0, 0, 2));
    rec_b.push_back(mk(5, 1, 0, 0, 10));
    exp_b.push_back(mk(5, 1, 0, 0, 7));
    exp_b.push_back(mk(5, 1, 0, 0, 3));
    for (int i = 0; i < 9; i++) rec_f.push_back(mk((i % 2) ? 2 : 1, 1, 0, 0, 1));
    for (int i = 0; i < 8; i++) exp_f.push_back(mk((i % 2) ? 2 : 1, 1, 0, 0, 1));
    rec_o.push_back(mk(2, 1, 1, 0, 3));
    exp_o.push_back(mk(2, 1, 1, 0, 3));
    rec_r.push_back(mk(7, 1, 0, 0, 2));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", obs, 0);
    chk("rst_valid", slot_valid, 0);
    chk("rst_rec", is_recording, 0);
    chk("rst_full", mem_full, 0);
    rst = 1'b0;

    sq = rec_a;
    record_run(1'b0, 1'b1);
    chk("valid_a", slot_valid, 2'b01);
    chk("full_a", mem_full, 0);
    eq = exp_a;
    play_run(1'b0, 1'b0, 1, 0);

    sq = rec_b;
    record_run(1'b1, 1'b1);
    chk("valid_b", slot_valid, 2'b11);
    eq = exp_b;
    play_run(1'b1, 1'b0, 1, 0);

    eq = exp_a;
    play_run(1'b0, 1'b1, 2, 10);
    stop_pulse = 1'b1;
    @(negedge clk);
    stop_pulse = 1'b0;
    loop_en = 1'b0;
    chk("stop_out", obs, 0);
    repeat (3) @(negedge clk);
    chk("stop_idle", obs, 0);

    sq = rec_f;
    record_run(1'b1, 1'b0);
    chk("full_rec", is_recording, 0);
    chk("full_flag", mem_full, 1);
    chk("full_valid", slot_valid, 2'b11);
    repeat (6) @(negedge clk);
    chk("no_restart", is_recording, 0);
    record_level = 1'b0;
    drive_live(mk(0, 0, 0, 0, 0));
    eq = exp_f;
    play_run(1'b1, 1'b0, 1, 0);

    sq = rec_o;
    record_run(1'b1, 1'b1);
    chk("full_cleared", mem_full, 0);
    @(negedge clk);
    slot_sel = 1'b0;
    clear_pulse = 1'b1;
    @(negedge clk);
    clear_pulse = 1'b0;
    chk("clear", slot_valid, 2'b10);
    play_pulse = 1'b1;
    @(negedge clk);
    play_pulse = 1'b0;
    chk("play_invalid", is_playing, 0);
    repeat (2) @(negedge clk);
    chk("play_invalid_out", obs, 0);
    eq = exp_o;
    play_run(1'b1, 1'b0, 1, 0);

    @(negedge clk);
    slot_sel = 1'b0;
    record_level = 1'b1;
    drive_live(mk(7, 1, 0, 0, 0));
    repeat (6) @(negedge clk);
    chk("mid_rec", is_recording, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rec_out", obs, 0);
    chk("rst_rec_flag", is_recording, 0);
    chk("rst_rec_valid", slot_valid, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_restart", is_recording, 0);
    record_level = 1'b0;
    drive_live(mk(0, 0, 0, 0, 0));

    sq = rec_r;
    record_run(1'b0, 1'b1);
    chk("valid_r", slot_valid, 2'b01);
    @(negedge clk);
    slot_sel = 1'b0;
    loop_en = 1'b0;
    play_pulse = 1'b1;
    @(negedge clk);
    play_pulse = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_play", obs, 8'hBC);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_play_out", obs, 0);
    chk("rst_play_valid", slot_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
